uart_msg_parser: RTL and testbench
==================================

# uart_msg_parser

Downstream stage of the UART byte receiver in the HFT accelerator front end. Consumes received bytes through the receiver's `rx_ready`/`rx_clear` handshake, delimits framed order messages (SOF, type, length, payload, checksum), and presents each complete, checked message on a valid/ready interface to the order-decode logic. Malformed, oversize or stalled frames are dropped and flagged with one-cycle error pulses.

## Interface
- `MAX_PAYLOAD`, 16: maximum payload bytes per frame (1..255).
- `TIMEOUT_CLKS`, 2000: idle clocks allowed between bytes inside a frame before abort (≥2).
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `rx_ready  in  1`: receiver holds a valid byte on `rx_data`. Level; drops the cycle after `rx_clear` is sampled high.
- `rx_data  in  8`: received byte.
- `rx_clear  out  1`: one-cycle consume pulse to the receiver.
- `msg_valid  out  1`: parsed message available.
- `msg_ready  in  1`: consumer accepts the message.
- `msg_type  out  8`: frame type byte.
- `msg_len  out  8`: payload length.
- `msg_payload  out  8*MAX_PAYLOAD`: payload; byte k at bits [8k+7:8k].
- `err_len  out  1`: pulse on LEN > MAX_PAYLOAD.
- `err_chk  out  1`: pulse on checksum mismatch.
- `err_timeout  out  1`: pulse on inter-byte timeout.

## Operation
- Frame: SOF = 0xA5, TYPE, LEN, LEN payload bytes, CHK. CHK = XOR of TYPE, LEN and all payload bytes.
- Byte handshake:
  - `rx_clear = rx_ready & (state != OUT) & ~clr_q`, where `clr_q` is `rx_clear` delayed one cycle.
  - A byte is consumed on the edge where `rx_clear` = 1.
  - `rx_clear` is never high while `rx_ready` = 0 and is never high on two consecutive cycles.
- States:
  - IDLE: consumed byte ≠ 0xA5 is discarded. 0xA5 → TYPE; payload register and checksum are cleared.
  - TYPE: capture `msg_type`, chk ^= byte → LEN.
  - LEN:
    - byte > MAX_PAYLOAD: `err_len` pulse → IDLE.
    - byte = 0: capture, chk ^= byte → CHK.
    - otherwise: capture, chk ^= byte → PAYLOAD.
  - PAYLOAD: write the byte at index idx (idx starts at 0), chk ^= byte, idx++. After byte LEN-1 → CHK.
  - CHK: byte == chk → OUT. Mismatch → `err_chk` pulse → IDLE.
  - OUT: `msg_valid` = 1. Consumption stalls, so the receiver is back-pressured. `msg_valid & msg_ready` → IDLE.
- Payload bytes at index ≥ LEN read 0.
- Timeout:
  - Counter runs in TYPE, LEN, PAYLOAD and CHK; it clears on every consumed byte and on each state entry.
  - When the count reaches TIMEOUT_CLKS: `err_timeout` pulse → IDLE.
  - Not active in IDLE or OUT.
- A 0xA5 received mid-frame is treated as data, not as resync.
- Reset at any point aborts the frame and returns to IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, `clr_q` 0.
- `rx_clear` asserts in the same cycle `rx_ready` is first seen high (combinational), subject to `clr_q` and state.
- `msg_valid` rises the cycle after the CHK byte is consumed. Frame latency from the CHK consume edge to `msg_valid` is 1 clk.
- `msg_type`, `msg_len` and `msg_payload` stay stable while `msg_valid` = 1.
- `msg_valid` falls the cycle after the handshake. The next `rx_clear` can assert in that same IDLE cycle.
- Error pulses last exactly 1 cycle and assert the cycle after the offending byte's consume edge, or the cycle after timeout expiry. They are mutually exclusive.
- Output `msg_*` registers are written only in TYPE/LEN/PAYLOAD. Their values outside OUT are don't-care but deterministic.

## Configuration
- `UART_MSG_CHECKSUM_EN` defined:
  - Frame includes the CHK byte; checking is as above.
- `UART_MSG_CHECKSUM_EN` undefined:
  - No CHK byte and no CHK state. After the last payload byte, or after LEN = 0, go directly to OUT.
  - `err_chk` is tied to 0.

## Structure
- Package `hft_uart_pkg` holds:
  - `UART_SOF` = 8'hA5;
  - the parser state enum `msg_state_t`;
  - default `MAX_PAYLOAD`/`TIMEOUT_CLKS` localparams, shared with the receiver.
- Sub-module `msg_timeout_ctr`:
  - parameter TIMEOUT_CLKS;
  - inputs `clk`, `rst`, `en`, `clr`;
  - output `expired` pulse.
- Byte-capture and checksum logic stays in the top module.

## Test plan
- **Good frame:** A5 01 03 11 22 33 CHK=0x03^0x01^0x11^0x22^0x33=0x02, `msg_ready` = 1.
  - Expect `msg_valid` for 1 cycle with type 0x01, len 3, payload[23:0] = 0x332211, upper bytes 0.
- **Bad checksum:** same frame with CHK = 0x05.
  - Expect `err_chk` for 1 cycle, no `msg_valid`, and the next good frame parses.
- **Oversize and zero length:**
  - LEN = MAX_PAYLOAD+1 → `err_len`; subsequent bytes are discarded until 0xA5.
  - A5 07 00 07 → message with len 0, payload all 0.
- **Backpressure:** hold `msg_ready` = 0 for 50 cycles after a good frame while the receiver offers the next byte.
  - Expect no `rx_clear` and stable `msg_*`. After release, the next byte is consumed 1 cycle after the handshake.
- **Timeout and reset:**
  - Send A5 01 then stall TIMEOUT_CLKS clocks → `err_timeout`, return to IDLE.
  - Assert `rst` after A5 01 02 → all outputs 0, and a fresh frame parses correctly.
- **Checksum disabled build:** A5 01 01 AA with `UART_MSG_CHECKSUM_EN` undefined → message with len 1, payload 0xAA, no CHK byte consumed.

Source files
------------

// File: rtl/hft_uart_pkg.sv
// hft_uart_pkg: shared UART front-end constants and parser state type (UART_MSG_CHECKSUM_EN adds the CHK state)
package hft_uart_pkg;
    localparam logic [7:0] UART_SOF = 8'hA5;
    localparam int DEF_MAX_PAYLOAD = 16;
    localparam int DEF_TIMEOUT_CLKS = 2000;
    typedef enum logic [2:0] {
        S_IDLE,
        S_TYPE,
        S_LEN,
        S_PAYLOAD,
`ifdef UART_MSG_CHECKSUM_EN
        S_CHK,
`endif
        S_OUT
    } msg_state_t;
endpackage

// File: rtl/uart_msg_parser_if.sv
// uart_msg_parser_if: receiver byte handshake, message valid/ready and error pulses
interface uart_msg_parser_if #(
    parameter int MAX_PAYLOAD = hft_uart_pkg::DEF_MAX_PAYLOAD
);
    logic                     rx_ready;
    logic [7:0]               rx_data;
    logic                     rx_clear;
    logic                     msg_valid;
    logic                     msg_ready;
    logic [7:0]               msg_type;
    logic [7:0]               msg_len;
    logic [8*MAX_PAYLOAD-1:0] msg_payload;
    logic                     err_len;
    logic                     err_chk;
    logic                     err_timeout;
    modport master (
        input  rx_ready, rx_data, msg_ready,
        output rx_clear, msg_valid, msg_type, msg_len, msg_payload, err_len, err_chk, err_timeout
    );
    modport slave (
        output rx_ready, rx_data, msg_ready,
        input  rx_clear, msg_valid, msg_type, msg_len, msg_payload, err_len, err_chk, err_timeout
    );
endinterface

// File: rtl/msg_timeout_ctr.sv
// msg_timeout_ctr: counts idle clocks while enabled and flags the TIMEOUT_CLKS-th one
module msg_timeout_ctr import hft_uart_pkg::*; #(
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CLKS);
    logic [W-1:0] cnt_q, cnt_d;
    assign expired = en & ~clr & (cnt_q == W'(TIMEOUT_CLKS - 1));
    // restart on every consumed byte, outside the frame states, and after expiry
    always_comb begin
        cnt_d = (clr | ~en | expired) ? '0 : cnt_q + W'(1);
    end
    // count register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_msg_parser.sv
// uart_msg_parser: frames SOF/TYPE/LEN/payload[/CHK] bytes into messages (UART_MSG_CHECKSUM_EN enables CHK byte)
module uart_msg_parser import hft_uart_pkg::*; #(
    parameter int MAX_PAYLOAD  = DEF_MAX_PAYLOAD,
    parameter int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
) (
    input logic               clk,
    input logic               rst,
    uart_msg_parser_if.master bus
);
`ifdef UART_MSG_CHECKSUM_EN
    localparam msg_state_t S_LAST = S_CHK;
`else
    localparam msg_state_t S_LAST = S_OUT;
`endif
    msg_state_t               state_q, state_d;
    logic                     clr_q;
    logic                     rx_clear;
    logic                     expired;
    logic [7:0]               chk_q, chk_d;
    logic [7:0]               idx_q, idx_d;
    logic [7:0]               type_q, type_d;
    logic [7:0]               len_q, len_d;
    logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;
    logic                     err_len_q, err_len_d;
    logic                     err_chk_q, err_chk_d;
    logic                     err_timeout_q, err_timeout_d;

    assign rx_clear = bus.rx_ready & (state_q != S_OUT) & ~clr_q;

    msg_timeout_ctr #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q != S_IDLE && state_q != S_OUT),
        .clr     (rx_clear),
        .expired (expired)
    );

    // frame FSM with byte capture and running XOR checksum
    always_comb begin
        state_d       = state_q;
        chk_d         = chk_q;
        idx_d         = idx_q;
        type_d        = type_q;
        len_d         = len_q;
        payload_d     = payload_q;
        err_len_d     = 1'b0;
        err_chk_d     = 1'b0;
        err_timeout_d = 1'b0;
        if (expired) begin
            state_d       = S_IDLE;
            err_timeout_d = 1'b1;
        end else if (state_q == S_OUT) begin
            state_d = bus.msg_ready ? S_IDLE : S_OUT;
        end else if (rx_clear) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_data == UART_SOF) begin
                        state_d   = S_TYPE;
                        chk_d     = '0;
                        idx_d     = '0;
                        payload_d = '0;
                    end
                end
                S_TYPE: begin
                    type_d  = bus.rx_data;
                    chk_d   = chk_q ^ bus.rx_data;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    if (bus.rx_data > 8'(MAX_PAYLOAD)) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = bus.rx_data;
                        chk_d   = chk_q ^ bus.rx_data;
                        state_d = (bus.rx_data == 8'd0) ? S_LAST : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    for (int k = 0; k < MAX_PAYLOAD; k++)
                        if (idx_q == 8'(k)) payload_d[8*k +: 8] = bus.rx_data;
                    chk_d   = chk_q ^ bus.rx_data;
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == len_q - 8'd1) ? S_LAST : S_PAYLOAD;
                end
`ifdef UART_MSG_CHECKSUM_EN
                S_CHK: begin
                    err_chk_d = bus.rx_data != chk_q;
                    state_d   = (bus.rx_data == chk_q) ? S_OUT : S_IDLE;
                end
`endif
                default: ;
            endcase
        end
    end

    // state, handshake history and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            clr_q         <= 1'b0;
            chk_q         <= '0;
            idx_q         <= '0;
            type_q        <= '0;
            len_q         <= '0;
            payload_q     <= '0;
            err_len_q     <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_q         <= rx_clear;
            chk_q         <= chk_d;
            idx_q         <= idx_d;
            type_q        <= type_d;
            len_q         <= len_d;
            payload_q     <= payload_d;
            err_len_q     <= err_len_d;
            err_chk_q     <= err_chk_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign bus.rx_clear    = rx_clear;
    assign bus.msg_valid   = state_q == S_OUT;
    assign bus.msg_type    = type_q;
    assign bus.msg_len     = len_q;
    assign bus.msg_payload = payload_q;
    assign bus.err_len     = err_len_q;
    assign bus.err_chk     = err_chk_q;
    assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_uart_msg_parser.sv
// tb_uart_msg_parser: directed frame table plus backpressure, timeout and reset sequences
module tb_uart_msg_parser;
    localparam int MP = 16;
    localparam int TO = 40;
    localparam int K_MSG = 0;
    localparam int K_LEN = 1;
    localparam int K_CHK = 2;

    typedef struct {
        logic [159:0] bytes;
        int           n;
        int           kind;
        logic [7:0]   typ;
        logic [7:0]   len;
        logic [127:0] pl;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic clr_prev = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    uart_msg_parser_if #(.MAX_PAYLOAD(MP)) bus ();
    uart_msg_parser #(.MAX_PAYLOAD(MP), .TIMEOUT_CLKS(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [159:0] b, input int n, input int kind, input logic [7:0] typ,
                       input logic [7:0] len, input logic [127:0] pl);
        vec_t v;
        v.bytes = b;
        v.n = n;
        v.kind = kind;
        v.typ = typ;
        v.len = len;
        v.pl = pl;
        vecs.push_back(v);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data = b;
        bus.rx_ready = 1'b1;
        @(negedge clk);
        while (!bus.rx_clear && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("consume", bus.rx_clear, 1'b1);
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bus.msg_ready = 1'b1;
        for (int i = 0; i < v.n; i++) begin
            send_byte(8'(v.bytes >> (8 * (v.n - 1 - i))));
            if (i < v.n - 1) begin
                check("mid_valid", bus.msg_valid, 1'b0);
                check("mid_err", {bus.err_len, bus.err_chk, bus.err_timeout}, 3'b000);
            end
        end
        if (v.kind == K_MSG) begin
            check("msg_valid", bus.msg_valid, 1'b1);
            check("msg_type", bus.msg_type, v.typ);
            check("msg_len", bus.msg_len, v.len);
            check("msg_payload", bus.msg_payload, v.pl);
            check("msg_err", {bus.err_len, bus.err_chk, bus.err_timeout}, 3'b000);
        end else begin
            check("err_pulse", {bus.err_len, bus.err_chk, bus.err_timeout},
                  (v.kind == K_LEN) ? 3'b100 : 3'b010);
            check("err_no_valid", bus.msg_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        check("after_valid", bus.msg_valid, 1'b0);
        check("after_err", {bus.err_len, bus.err_chk, bus.err_timeout}, 3'b000);
    endtask

    // rx_clear must only follow a held byte and never repeat on consecutive cycles
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_clear && (!bus.rx_ready || clr_prev)) begin
                errors++;
                $display("FAIL rx_clear_protocol: rx_clear=%b rx_ready=%b prev=%b", bus.rx_clear, bus.rx_ready, clr_prev);
            end
            clr_prev = bus.rx_clear;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] big_pl = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        logic [127:0] big_tx = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        logic [159:0] snap;
        logic         seen;
        vec_t         good;
        int           n;
        rst = 1'b1;
        bus.rx_ready = 1'b0;
        bus.rx_data = 8'h00;
        bus.msg_ready = 1'b1;
`ifdef UART_MSG_CHECKSUM_EN
        add(160'hA501031122_3302, 7, K_MSG, 8'h01, 8'd3, 128'h332211);
        add(160'hA501031122_3305, 7, K_CHK, 8'h00, 8'd0, 128'h0);
        add(160'hA50111, 3, K_LEN, 8'h00, 8'd0, 128'h0);
        add(160'h1122A5070007, 6, K_MSG, 8'h07, 8'd0, 128'h0);
        add(160'hA50101AAAA, 5, K_MSG, 8'h01, 8'd1, 128'hAA);
        add(160'({8'hA5, 8'hA5, 8'h10, big_tx, 8'hB5}), 20, K_MSG, 8'hA5, 8'd16, big_pl);
        add(160'hA5020002, 4, K_MSG, 8'h02, 8'd0, 128'h0);
        good.bytes = 160'hA501031122_3302;
        good.n = 7;
`else
        add(160'hA501031122_33, 6, K_MSG, 8'h01, 8'd3, 128'h332211);
        add(160'hA50111, 3, K_LEN, 8'h00, 8'd0, 128'h0);
        add(160'h1122A50700, 5, K_MSG, 8'h07, 8'd0, 128'h0);
        add(160'hA50101AA, 4, K_MSG, 8'h01, 8'd1, 128'hAA);
        add(160'({8'hA5, 8'hA5, 8'h10, big_tx}), 19, K_MSG, 8'hA5, 8'd16, big_pl);
        add(160'hA50200, 3, K_MSG, 8'h02, 8'd0, 128'h0);
        good.bytes = 160'hA501031122_33;
        good.n = 6;
`endif
        good.kind = K_MSG;
        good.typ = 8'h01;
        good.len = 8'd3;
        good.pl = 128'h332211;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.rx_clear, bus.msg_valid, bus.msg_type, bus.msg_len, bus.msg_payload,
                                bus.err_len, bus.err_chk, bus.err_timeout}, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        bus.rx_data = 8'h33;
        bus.rx_ready = 1'b1;
        #1;
        check("rx_clear_comb", bus.rx_clear, 1'b1);
        @(posedge clk);
        #1;
        check("rx_clear_gap", bus.rx_clear, 1'b0);
        bus.rx_ready = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        bus.msg_ready = 1'b0;
        for (int i = 0; i < good.n; i++) send_byte(8'(good.bytes >> (8 * (good.n - 1 - i))));
        check("bp_valid", bus.msg_valid, 1'b1);
        bus.rx_data = 8'hA5;
        bus.rx_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            snap = {bus.rx_clear, bus.msg_valid, bus.msg_type, bus.msg_len, bus.msg_payload};
            check("bp_hold", snap, {1'b0, 1'b1, 8'h01, 8'd3, 128'h332211});
        end
        @(posedge clk);
        #1;
        bus.msg_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", bus.msg_valid, 1'b0);
        check("bp_next_consume", bus.rx_clear, 1'b1);
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
        send_byte(8'h01);
        send_byte(8'h00);
`ifdef UART_MSG_CHECKSUM_EN
        send_byte(8'h01);
`endif
        check("bp_next_valid", bus.msg_valid, 1'b1);
        check("bp_next_type", bus.msg_type, 8'h01);
        check("bp_next_len", bus.msg_len, 8'd0);
        check("bp_next_payload", bus.msg_payload, 128'h0);
        @(posedge clk);
        #1;

        send_byte(8'hA5);
        send_byte(8'h01);
        n = 0;
        while (n < TO + 10 && !bus.err_timeout) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_pulse", bus.err_timeout, 1'b1);
        check("timeout_cycles", (n >= TO - 1) && (n <= TO + 1), 1'b1);
        check("timeout_only", {bus.err_len, bus.err_chk, bus.msg_valid}, 3'b000);
        @(posedge clk);
        #1;
        check("timeout_one_cycle", bus.err_timeout, 1'b0);
        seen = 1'b0;
        repeat (TO + 10) begin
            @(posedge clk);
            #1;
            seen |= bus.err_timeout;
        end
        check("no_timeout_idle", seen, 1'b0);
        run_vec(good);

        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_reset_outputs", {bus.rx_clear, bus.msg_valid, bus.msg_type, bus.msg_len, bus.msg_payload,
                                    bus.err_len, bus.err_chk, bus.err_timeout}, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec(good);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
